soc910_apb_ctrl: RTL and testbench

AXI-Lite to APB controller for the soc910 peripheral subsystem. It accepts one AXI-Lite transaction at a time from the narrow peripheral path and arbitrates between pending reads and writes. It decodes the address against a runtime address map and sequences a single APB transfer (SETUP/ACCESS) on the selected one of `NumSlaves` APB ports, then returns the AXI-Lite response.

---
 rtl/soc910_pkg.sv | 96 +++++++++
 rtl/soc910_apb_decode.sv | 34 +++
 rtl/soc910_apb_ctrl.sv | 166 ++++++++++++++++
 tb/tb_soc910_apb_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc910_pkg.sv
// Shared soc910 peripheral-subsystem types: AXI-Lite and APB channel structs,
// the APB address rule, and controller defaults.
package soc910_pkg;

  localparam int unsigned AxiAddrWidth     = 40;
  localparam int unsigned AxiDataWidth     = 32;
  localparam int unsigned AxiStrbWidth     = AxiDataWidth / 8;
  localparam int unsigned ApbNumSlaves     = 4;
  localparam int unsigned ApbTimeoutCycles = 256;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  typedef logic [AxiAddrWidth-1:0] addr_t;
  typedef logic [AxiDataWidth-1:0] data_t;
  typedef logic [AxiStrbWidth-1:0] strb_t;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2,
    APB_RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    addr_t start_addr;
    addr_t end_addr;
  } apb_rule_t;

  typedef struct packed {
    addr_t      addr;
    logic [2:0] prot;
  } axi_lite_ax_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
  } axi_lite_w_t;

  typedef struct packed {
    logic [1:0] resp;
  } axi_lite_b_t;

  typedef struct packed {
    data_t      data;
    logic [1:0] resp;
  } axi_lite_r_t;

  typedef struct packed {
    axi_lite_ax_t aw;
    logic         aw_valid;
    axi_lite_w_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_lite_ax_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_lite_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    axi_lite_b_t b;
    logic        b_valid;
    logic        ar_ready;
    axi_lite_r_t r;
    logic        r_valid;
  } axi_lite_resp_t;

  typedef struct packed {
    addr_t      paddr;
    logic [2:0] pprot;
    logic       psel;
    logic       penable;
    logic       pwrite;
    data_t      pwdata;
    strb_t      pstrb;
  } apb_req_t;

  typedef struct packed {
    logic  pready;
    data_t prdata;
    logic  pslverr;
  } apb_resp_t;

  // Slave-index width, kept at least one bit so a single-slave build still elaborates.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [1:0] resp_from_err(input logic err);
    return err ? RespSlvErr : RespOkay;
  endfunction

endpackage

// File: rtl/soc910_apb_decode.sv
// Priority address decoder: first rule (lowest index) whose [start, end) range
// contains the address selects the slave.
module soc910_apb_decode
  import soc910_pkg::*;
#(
  parameter int unsigned NumSlaves = ApbNumSlaves
) (
  input  addr_t                             addr,
  input  apb_rule_t                         addr_map [NumSlaves],
  output logic [idx_width(NumSlaves)-1:0]   slv_idx,
  output logic                              hit
);

  localparam int unsigned IdxWidth = idx_width(NumSlaves);

  logic [NumSlaves-1:0] match;

  for (genvar gi = 0; gi < NumSlaves; gi++) begin : g_match
    assign match[gi] = (addr >= addr_map[gi].start_addr) && (addr < addr_map[gi].end_addr);
  end

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    slv_idx = '0;
    hit     = 1'b0;
    for (int i = NumSlaves - 1; i >= 0; i--) begin
      if (match[i]) begin
        slv_idx = IdxWidth'(i);
        hit     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/soc910_apb_ctrl.sv
// AXI-Lite to APB bridge: one transaction at a time, alternating read/write priority.
// Optional ACCESS-phase timeout is built when SOC910_APB_TIMEOUT_EN is defined.
module soc910_apb_ctrl
  import soc910_pkg::*;
#(
  parameter int unsigned NumSlaves     = ApbNumSlaves,
  parameter int unsigned TimeoutCycles = ApbTimeoutCycles
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  apb_rule_t      addr_map_i [NumSlaves],
  input  axi_lite_req_t  axi_lite_req_i,
  output axi_lite_resp_t axi_lite_rsp_o,
  output apb_req_t       apb_req_o [NumSlaves],
  input  apb_resp_t      apb_rsp_i [NumSlaves]
);

  localparam int unsigned IdxWidth = idx_width(NumSlaves);

  apb_state_e          state_reg, state_next;
  logic                prio_read_reg;
  addr_t               addr_reg;
  logic [2:0]          prot_reg;
  data_t               wdata_reg;
  strb_t               wstrb_reg;
  logic                write_reg;
  logic [IdxWidth-1:0] sel_reg;
  logic [1:0]          resp_reg;
  data_t               rdata_reg;

  logic                wr_pend, rd_pend, grant_wr, grant_rd, idle_ok, accept;
  addr_t               dec_addr;
  logic [IdxWidth-1:0] dec_idx;
  logic                dec_hit;
  apb_resp_t           sel_rsp;
  logic                resp_done;
  logic                timeout_hit;

  assign wr_pend  = axi_lite_req_i.aw_valid & axi_lite_req_i.w_valid;
  assign rd_pend  = axi_lite_req_i.ar_valid;
  assign grant_wr = wr_pend & (~rd_pend | ~prio_read_reg);
  assign grant_rd = rd_pend & ~grant_wr;
  // Readies must stay low while reset is held even if valids are already up.
  assign idle_ok  = (state_reg == APB_IDLE) & ~rst_i;
  assign accept   = idle_ok & (grant_wr | grant_rd);
  assign dec_addr = grant_wr ? axi_lite_req_i.aw.addr : axi_lite_req_i.ar.addr;

  assign sel_rsp   = apb_rsp_i[sel_reg];
  assign resp_done = write_reg ? axi_lite_req_i.b_ready : axi_lite_req_i.r_ready;

  soc910_apb_decode #(
    .NumSlaves (NumSlaves)
  ) u_decode (
    .addr     (dec_addr),
    .addr_map (addr_map_i),
    .slv_idx  (dec_idx),
    .hit      (dec_hit)
  );

`ifdef SOC910_APB_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
  logic [CntWidth-1:0] cnt_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else if (state_reg == APB_SETUP) begin
      cnt_reg <= '0;
    end else if ((state_reg == APB_ACCESS) && !sel_rsp.pready) begin
      cnt_reg <= cnt_reg + CntWidth'(1);
    end
  end

  // Fires in the last allowed ACCESS cycle only if pready is still low.
  assign timeout_hit = (state_reg == APB_ACCESS) && !sel_rsp.pready &&
                       (cnt_reg == CntWidth'(TimeoutCycles - 1));
`else
  logic timeout_unused;
  assign timeout_unused = (TimeoutCycles != 0);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= APB_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      APB_IDLE:   if (accept) state_next = dec_hit ? APB_SETUP : APB_RESP;
      APB_SETUP:  state_next = APB_ACCESS;
      APB_ACCESS: if (sel_rsp.pready || timeout_hit) state_next = APB_RESP;
      APB_RESP:   if (resp_done) state_next = APB_IDLE;
      default:    state_next = APB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_read_reg <= 1'b0;
      write_reg     <= 1'b0;
      addr_reg      <= '0;
      prot_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      sel_reg       <= '0;
      resp_reg      <= RespOkay;
      rdata_reg     <= '0;
    end else begin
      if (accept) begin
        prio_read_reg <= ~prio_read_reg;
        write_reg     <= grant_wr;
        addr_reg      <= dec_addr;
        prot_reg      <= grant_wr ? axi_lite_req_i.aw.prot : axi_lite_req_i.ar.prot;
        wdata_reg     <= grant_wr ? axi_lite_req_i.w.data : '0;
        wstrb_reg     <= grant_wr ? axi_lite_req_i.w.strb : '0;
        sel_reg       <= dec_idx;
        if (!dec_hit) begin
          resp_reg  <= RespDecErr;
          rdata_reg <= '0;
        end
      end
      if (state_reg == APB_ACCESS) begin
        if (sel_rsp.pready) begin
          resp_reg <= resp_from_err(sel_rsp.pslverr);
          if (!write_reg) rdata_reg <= sel_rsp.prdata;
        end else if (timeout_hit) begin
          resp_reg  <= RespSlvErr;
          rdata_reg <= '0;
        end
      end
    end
  end

  always_comb begin
    axi_lite_rsp_o          = '0;
    axi_lite_rsp_o.aw_ready = accept & grant_wr;
    axi_lite_rsp_o.w_ready  = accept & grant_wr;
    axi_lite_rsp_o.ar_ready = accept & grant_rd;
    axi_lite_rsp_o.b.resp   = resp_reg;
    axi_lite_rsp_o.b_valid  = (state_reg == APB_RESP) & write_reg;
    axi_lite_rsp_o.r.data   = rdata_reg;
    axi_lite_rsp_o.r.resp   = resp_reg;
    axi_lite_rsp_o.r_valid  = (state_reg == APB_RESP) & ~write_reg;
  end

  // psel/penable come from state only, so pready never reaches them combinationally.
  for (genvar gi = 0; gi < NumSlaves; gi++) begin : g_apb
    always_comb begin
      apb_req_o[gi]         = '0;
      apb_req_o[gi].paddr   = addr_reg;
      apb_req_o[gi].pprot   = prot_reg;
      apb_req_o[gi].pwrite  = write_reg;
      apb_req_o[gi].pwdata  = wdata_reg;
      apb_req_o[gi].pstrb   = wstrb_reg;
      apb_req_o[gi].psel    = ((state_reg == APB_SETUP) || (state_reg == APB_ACCESS)) &&
                              (sel_reg == IdxWidth'(gi));
      apb_req_o[gi].penable = (state_reg == APB_ACCESS) && (sel_reg == IdxWidth'(gi));
    end
  end

endmodule

// File: tb/tb_soc910_apb_ctrl.sv
// Self-checking bench for soc910_apb_ctrl: vector table through a scoreboard, plus
// arbitration, reset-in-ACCESS and (with SOC910_APB_TIMEOUT_EN) timeout sequences.
module tb_soc910_apb_ctrl;
  import soc910_pkg::*;

  typedef struct {
    bit          is_write;
    logic [39:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          wait_cyc;
    logic [31:0] prdata;
    bit          slverr;
    int          rdelay;
    logic [3:0]  exp_sel;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
    int          exp_lat;
    int          exp_acc;
  } vec_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          lat;
    logic [3:0]  sel;
    int          acc;
  } exp_t;

  logic           clk;
  logic           rst;
  apb_rule_t      addr_map [4];
  axi_lite_req_t  req;
  axi_lite_resp_t rsp;
  apb_req_t       apb_req [4];
  apb_resp_t      apb_rsp [4];

  int          cyc = 0;
  int          acc_cnt;
  int          cfg_wait = 0;
  logic [31:0] cfg_prdata = '0;
  bit          cfg_slverr = 0;
  logic        any_en;
  int          errors = 0;
  int          checks = 0;
  exp_t        sb [$];
  vec_t        vecs [8];

  soc910_apb_ctrl #(
    .NumSlaves     (4),
    .TimeoutCycles (4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .addr_map_i     (addr_map),
    .axi_lite_req_i (req),
    .axi_lite_rsp_o (rsp),
    .apb_req_o      (apb_req),
    .apb_rsp_i      (apb_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // APB slave model: the selected slave answers after cfg_wait ACCESS cycles;
  // unselected slaves present hostile values that the DUT must ignore.
  always_comb begin
    any_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apb_rsp[i].pready  = 1'b1;
      apb_rsp[i].prdata  = 32'hDEAD_BEEF;
      apb_rsp[i].pslverr = 1'b1;
      if (apb_req[i].psel) begin
        apb_rsp[i].pready  = apb_req[i].penable && (acc_cnt >= cfg_wait);
        apb_rsp[i].prdata  = cfg_prdata;
        apb_rsp[i].pslverr = cfg_slverr;
      end
      if (apb_req[i].psel && apb_req[i].penable) any_en = 1'b1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) acc_cnt <= 0;
    else if (any_en) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] sel_mask();
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = apb_req[i].psel;
    return m;
  endfunction

  function automatic logic [3:0] en_mask();
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = apb_req[i].penable;
    return m;
  endfunction

  function automatic vec_t mk(input bit w, input logic [39:0] a, input logic [31:0] wd,
                              input logic [3:0] st, input logic [2:0] pr, input int wt,
                              input logic [31:0] prd, input bit se, input int rd,
                              input logic [3:0] esel, input logic [1:0] eresp,
                              input logic [31:0] edata, input int elat, input int eacc);
    vec_t v;
    v.is_write = w;   v.addr = a;       v.wdata = wd;      v.strb = st;
    v.prot = pr;      v.wait_cyc = wt;  v.prdata = prd;    v.slverr = se;
    v.rdelay = rd;    v.exp_sel = esel; v.exp_resp = eresp; v.exp_data = edata;
    v.exp_lat = elat; v.exp_acc = eacc;
    return v;
  endfunction

  task automatic clear_valids();
    req.aw_valid = 1'b0;
    req.w_valid  = 1'b0;
    req.ar_valid = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input string name);
    exp_t       e, got_e;
    logic [3:0] sel_seen;
    int         acc_seen, t_acc, t_val;
    bit         ok, fields_ok, hold_ok;
    cfg_wait   = v.wait_cyc;
    cfg_prdata = v.prdata;
    cfg_slverr = v.slverr;
    if (v.is_write) begin
      req.aw.addr = v.addr; req.aw.prot = v.prot;
      req.w.data  = v.wdata; req.w.strb = v.strb;
      req.aw_valid = 1'b1;  req.w_valid = 1'b1;
    end else begin
      req.ar.addr = v.addr; req.ar.prot = v.prot;
      req.ar_valid = 1'b1;
    end
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (v.is_write ? rsp.aw_ready : rsp.ar_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      check({name, "_accept"}, 0, 1);
      clear_valids();
      return;
    end
    check({name, "_readies"}, {rsp.aw_ready, rsp.w_ready, rsp.ar_ready},
          v.is_write ? 3'b110 : 3'b001);
    t_acc  = cyc;
    e.resp = v.exp_resp; e.data = v.exp_data; e.lat = v.exp_lat;
    e.sel  = v.exp_sel;  e.acc  = v.exp_acc;
    sb.push_back(e);
    @(negedge clk);
    clear_valids();
    sel_seen = '0; acc_seen = 0; fields_ok = 1; ok = 0;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (rsp.b_valid || rsp.r_valid) begin ok = 1; break; end
      for (int j = 0; j < 4; j++) begin
        if (apb_req[j].psel) begin
          sel_seen[j] = 1'b1;
          if (apb_req[j].penable) acc_seen++;
          if (apb_req[j].paddr !== v.addr || apb_req[j].pwrite !== v.is_write ||
              apb_req[j].pprot !== v.prot) fields_ok = 0;
          if (v.is_write && (apb_req[j].pwdata !== v.wdata || apb_req[j].pstrb !== v.strb))
            fields_ok = 0;
        end
      end
      @(negedge clk);
    end
    t_val = cyc;
    got_e = sb.pop_front();
    if (!ok) begin
      check({name, "_resp_timeout"}, 0, 1);
      return;
    end
    check({name, "_kind"}, {rsp.b_valid, rsp.r_valid}, v.is_write ? 2'b10 : 2'b01);
    check({name, "_resp"}, v.is_write ? rsp.b.resp : rsp.r.resp, got_e.resp);
    if (!v.is_write) check({name, "_rdata"}, rsp.r.data, got_e.data);
    check({name, "_latency"}, t_val - t_acc, got_e.lat);
    check({name, "_psel"}, sel_seen, got_e.sel);
    check({name, "_access_cycles"}, acc_seen, got_e.acc);
    if (got_e.sel != 4'b0000) check({name, "_apb_fields"}, fields_ok, 1);
    hold_ok = 1;
    for (int d = 0; d < v.rdelay; d++) begin
      @(negedge clk);
      #1;
      if (!(rsp.b_valid || rsp.r_valid)) hold_ok = 0;
    end
    if (v.rdelay > 0) check({name, "_hold"}, hold_ok, 1);
    req.b_ready = v.is_write;
    req.r_ready = !v.is_write;
    @(negedge clk);
    #1;
    check({name, "_drop"}, {rsp.b_valid, rsp.r_valid}, 2'b00);
    req.b_ready = 1'b0;
    req.r_ready = 1'b0;
    $display("txn %s: write=%0d addr=%0h psel=%b lat=%0d resp=%0h", name, v.is_write,
             v.addr, sel_seen, t_val - t_acc, v.is_write ? rsp.b.resp : rsp.r.resp);
    @(negedge clk);
  endtask

  initial begin
    bit gw [4];
    int gc [4];
    int ng;
    bit ok, both, pair_ok, quiet;

    addr_map[0] = '{40'h00_0000_1000, 40'h00_0000_2000};
    addr_map[1] = '{40'h00_0300_0000, 40'h00_0300_1000};
    addr_map[2] = '{40'h00_0400_0000, 40'h00_0400_1000};
    addr_map[3] = '{40'h00_0000_1800, 40'h00_0000_3000};

    //            W  addr             wdata         strb   prot  wt prdata        se rd  sel     resp   data          lat acc
    vecs[0] = mk(1, 40'h00_0300_0000, 32'h1234_5678, 4'hF, 3'd0, 0, 32'h0,         0, 0, 4'b0010, 2'b00, 32'h0,         3, 1);
    vecs[1] = mk(0, 40'h00_0400_0010, 32'h0,         4'h0, 3'd2, 5, 32'hCAFE_F00D, 1, 0, 4'b0100, 2'b10, 32'hCAFE_F00D, 8, 6);
    vecs[2] = mk(0, 40'h00_0000_0000, 32'h0,         4'h0, 3'd0, 0, 32'h1111_1111, 0, 0, 4'b0000, 2'b11, 32'h0,         1, 0);
    vecs[3] = mk(0, 40'h00_0000_1900, 32'h0,         4'h0, 3'd0, 2, 32'h0BAD_CAFE, 0, 0, 4'b0001, 2'b00, 32'h0BAD_CAFE, 5, 3);
    vecs[4] = mk(1, 40'h00_0000_2FFF, 32'hA5A5_5A5A, 4'h5, 3'd1, 1, 32'h0,         0, 0, 4'b1000, 2'b00, 32'h0,         4, 2);
    vecs[5] = mk(1, 40'h00_0300_1000, 32'h0F0F_0F0F, 4'hF, 3'd0, 0, 32'h0,         0, 0, 4'b0000, 2'b11, 32'h0,         1, 0);
    vecs[6] = mk(0, 40'h00_0300_0FFF, 32'h0,         4'h0, 3'd5, 0, 32'h5555_AAAA, 0, 3, 4'b0010, 2'b00, 32'h5555_AAAA, 3, 1);
    vecs[7] = mk(1, 40'h00_0400_0000, 32'hFFFF_0000, 4'hC, 3'd0, 0, 32'h0,         1, 0, 4'b0100, 2'b10, 32'h0,         3, 1);

    // Reset state, with every request valid already asserted.
    req = '0;
    rst = 1'b1;
    req.aw_valid = 1'b1; req.w_valid = 1'b1; req.ar_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_aw_w_ready", {rsp.aw_ready, rsp.w_ready}, 2'b00);
    check("reset_ar_ready", rsp.ar_ready, 0);
    check("reset_valids", {rsp.b_valid, rsp.r_valid}, 2'b00);
    check("reset_psel", sel_mask(), 4'b0000);
    check("reset_penable", en_mask(), 4'b0000);
    check("reset_paddr", apb_req[0].paddr, 40'h0);
    check("reset_pwrite_pstrb", {apb_req[2].pwrite, apb_req[2].pstrb}, 5'b0);
    check("reset_rsp_data", {rsp.b.resp, rsp.r.resp, rsp.r.data}, 36'h0);
    clear_valids();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset pulsed while a write sits in ACCESS.
    cfg_wait = 1000;
    req.aw.addr = 40'h00_0300_0000; req.aw.prot = 3'd0;
    req.w.data = 32'h7777_7777; req.w.strb = 4'hF;
    req.aw_valid = 1'b1; req.w_valid = 1'b1;
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (rsp.aw_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    check("rst_mid_accept", ok, 1);
    @(negedge clk);
    clear_valids();
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (apb_req[1].penable) begin ok = 1; break; end
      @(negedge clk);
    end
    check("rst_mid_reach_access", ok, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_psel", sel_mask(), 4'b0000);
    check("rst_mid_penable", en_mask(), 4'b0000);
    quiet = 1;
    req.b_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      if (rsp.b_valid || rsp.r_valid) quiet = 0;
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      if (rsp.b_valid || rsp.r_valid) quiet = 0;
    end
    check("rst_mid_no_response", quiet, 1);
    req.b_ready = 1'b0;
    @(negedge clk);
    run_txn(mk(1, 40'h00_0300_0008, 32'h2468_ACE0, 4'h3, 3'd0, 0, 32'h0, 0, 0,
               4'b0010, 2'b00, 32'h0, 3, 1), "after_reset_write");

    // Arbitration: AW+W and AR held valid from reset onward.
    rst = 1'b1;
    cfg_wait = 0; cfg_slverr = 0;
    req.aw.addr = 40'h00_0300_0000; req.w.data = 32'hABCD_0123; req.w.strb = 4'hF;
    req.ar.addr = 40'h00_0300_0004;
    req.aw_valid = 1'b1; req.w_valid = 1'b1; req.ar_valid = 1'b1;
    req.b_ready = 1'b1; req.r_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ng = 0; both = 0; pair_ok = 1;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      #1;
      if (rsp.aw_ready && rsp.ar_ready) both = 1;
      if (rsp.aw_ready != rsp.w_ready) pair_ok = 0;
      if (rsp.aw_ready) begin gw[ng] = 1; gc[ng] = cyc; ng++; end
      else if (rsp.ar_ready) begin gw[ng] = 0; gc[ng] = cyc; ng++; end
      @(negedge clk);
    end
    clear_valids();
    check("arb_grant_count", ng, 4);
    for (int i = 0; i < ng; i++)
      check($sformatf("arb_grant%0d_is_write", i), gw[i], (i % 2) == 0);
    for (int i = 1; i < ng; i++)
      check($sformatf("arb_gap%0d", i), gc[i] - gc[i-1], 4);
    check("arb_exclusive", both, 0);
    check("arb_aw_w_pair", pair_ok, 1);
    $display("txn arbitration: grants=%0d", ng);
    repeat (8) @(negedge clk);
    #1;
    check("arb_drained", {rsp.b_valid, rsp.r_valid}, 2'b00);
    req.b_ready = 1'b0; req.r_ready = 1'b0;
    @(negedge clk);

`ifdef SOC910_APB_TIMEOUT_EN
    run_txn(mk(0, 40'h00_0400_0000, 32'h0, 4'h0, 3'd0, 1000, 32'h1234_5678, 0, 0,
               4'b0100, 2'b10, 32'h0, 6, 4), "timeout_abort");
    run_txn(mk(0, 40'h00_0400_0020, 32'h0, 4'h0, 3'd0, 3, 32'h8765_4321, 0, 0,
               4'b0100, 2'b00, 32'h8765_4321, 6, 4), "timeout_last_cycle");
`endif

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
